// File: rtl/delay_sweep_ctrl.sv
// Delay-line tap sweep sequencer: steps sel_data through [start, stop], dwelling on each value
// and flagging the first samples after each change. Define DELAY_SWEEP_PINGPONG_EN for up/down sweeps.
module delay_sweep_ctrl #(
    parameter int SIZE    = 5,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [SIZE-1:0]    cfg_start,
    input  logic [SIZE-1:0]    cfg_stop,
    input  logic [SIZE-1:0]    cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [DWELL_W-1:0] cfg_blank,
    input  logic               cfg_repeat,
    input  logic               cmd_go,
    input  logic               cmd_abort,
    input  logic               sample_stb,
    output logic [SIZE-1:0]    sel_data,
    output logic               sel_valid,
    output logic               blank,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE = 2'd0, DWELL = 2'd1, STEP = 2'd2, DONE = 2'd3} state_t;

    state_t             state_r, state_s;
    logic [SIZE-1:0]    start_r, stop_r, step_r;
    logic [DWELL_W-1:0] dwell_r, blank_cfg_r;
    logic               repeat_r;
    logic [DWELL_W-1:0] count_r, count_s;
    logic [SIZE-1:0]    sel_data_r, sel_data_s;
    logic               sel_valid_r, sel_valid_s;
    logic               blank_r, blank_s, busy_r, busy_s, done_r, done_s;
    logic               dir_r, dir_s;
    logic               load_s, stb_ok_s, dwell_end_s, pass_done_s, step_dir_s;
    logic [SIZE:0]      up_next_s;
    logic [SIZE-1:0]    step_val_s;
    logic [DWELL_W-1:0] dwell_last_s, blank_lim_s;

    // Strobes coinciding with a sel_valid pulse belong to the previous tap and are not counted.
    assign load_s       = (state_r == IDLE) && cmd_go && !cmd_abort;
    assign stb_ok_s     = sample_stb && !sel_valid_r;
    assign dwell_last_s = (dwell_r == {DWELL_W{1'b0}}) ? {DWELL_W{1'b0}} : (dwell_r - DWELL_W'(1));
    assign dwell_end_s  = (state_r == DWELL) && stb_ok_s && (count_r == dwell_last_s);
    assign up_next_s    = {1'b0, sel_data_r} + {1'b0, step_r};
    assign blank_lim_s  = load_s ? cfg_blank : blank_cfg_r;

    // Step decision: next tap value, direction, and whether the pass is complete.
    always_comb begin
        pass_done_s = 1'b0;
        step_val_s  = up_next_s[SIZE-1:0];
        step_dir_s  = dir_r;
        if ((step_r == {SIZE{1'b0}}) || (start_r > stop_r)) begin
            pass_done_s = 1'b1;
`ifdef DELAY_SWEEP_PINGPONG_EN
        end else if (dir_r || (up_next_s > {1'b0, stop_r})) begin
            step_dir_s = 1'b1;
            step_val_s = sel_data_r - step_r;
            if ({1'b0, sel_data_r} < ({1'b0, start_r} + {1'b0, step_r})) begin
                pass_done_s = 1'b1;
            end else begin
                pass_done_s = 1'b0;
            end
`else
        end else if (up_next_s > {1'b0, stop_r}) begin
            pass_done_s = 1'b1;
`endif
        end else begin
            pass_done_s = 1'b0;
        end
    end

    // Next-state logic; abort overrides everything.
    always_comb begin
        state_s = state_r;
        if (cmd_abort) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    if (cmd_go) state_s = DWELL; else state_s = IDLE;
                DWELL:   if (dwell_end_s) state_s = STEP; else state_s = DWELL;
                STEP:    if (pass_done_s && !repeat_r) state_s = DONE; else state_s = DWELL;
                DONE:    state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        sel_data_s  = sel_data_r;
        sel_valid_s = 1'b0;
        count_s     = count_r;
        dir_s       = dir_r;
        if (cmd_abort) begin
            count_s = {DWELL_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (load_s) begin
                        sel_data_s  = cfg_start;
                        sel_valid_s = 1'b1;
                        count_s     = {DWELL_W{1'b0}};
                        dir_s       = 1'b0;
                    end else begin
                        count_s = {DWELL_W{1'b0}};
                    end
                end
                DWELL: begin
                    if (dwell_end_s) begin
                        count_s = {DWELL_W{1'b0}};
                    end else if (stb_ok_s) begin
                        count_s = count_r + DWELL_W'(1);
                    end else begin
                        count_s = count_r;
                    end
                end
                STEP: begin
                    if (pass_done_s && repeat_r) begin
                        sel_data_s  = start_r;
                        sel_valid_s = 1'b1;
                        dir_s       = 1'b0;
                    end else if (pass_done_s) begin
                        sel_data_s = sel_data_r;
                    end else begin
                        sel_data_s  = step_val_s;
                        sel_valid_s = 1'b1;
                        dir_s       = step_dir_s;
                    end
                end
                DONE:    count_s = {DWELL_W{1'b0}};
                default: count_s = {DWELL_W{1'b0}};
            endcase
        end
        busy_s  = (state_s == DWELL) || (state_s == STEP);
        done_s  = (state_s == DONE);
        blank_s = (state_s == DWELL) && (blank_lim_s != {DWELL_W{1'b0}}) && (count_s < blank_lim_s);
    end

    // State, shadow configuration and output registers.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_r     <= IDLE;
            start_r     <= {SIZE{1'b0}};
            stop_r      <= {SIZE{1'b0}};
            step_r      <= {SIZE{1'b0}};
            dwell_r     <= {DWELL_W{1'b0}};
            blank_cfg_r <= {DWELL_W{1'b0}};
            repeat_r    <= 1'b0;
            count_r     <= {DWELL_W{1'b0}};
            sel_data_r  <= {SIZE{1'b0}};
            sel_valid_r <= 1'b0;
            blank_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dir_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            count_r     <= count_s;
            sel_data_r  <= sel_data_s;
            sel_valid_r <= sel_valid_s;
            blank_r     <= blank_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            dir_r       <= dir_s;
            if (load_s) begin
                start_r     <= cfg_start;
                stop_r      <= cfg_stop;
                step_r      <= cfg_step;
                dwell_r     <= cfg_dwell;
                blank_cfg_r <= cfg_blank;
                repeat_r    <= cfg_repeat;
            end
        end
    end

    assign sel_data  = sel_data_r;
    assign sel_valid = sel_valid_r;
    assign blank     = blank_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: doc/delay_sweep_ctrl.md
# delay_sweep_ctrl

Sequencer that programs the tap select of the variable delay line (`sel_data`/`sel_valid`). It steps the delay through a configured range, holding each value for a programmed number of accepted samples. It also flags the first samples after each change so downstream can blank the discontinuity. It sits beside the delay line in the DSP chain, is driven from the settings bus, and counts samples from the line's accept strobe.

## Interface
- `SIZE`, 5, width of delay select (max delay 2^SIZE-1)
- `DWELL_W`, 16, width of dwell/blank sample counters
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high
- `clear` in 1: synchronous soft clear, same effect as `reset`
- `cfg_start` in SIZE: first delay value
- `cfg_stop` in SIZE: last delay value (inclusive bound)
- `cfg_step` in SIZE: increment per step
- `cfg_dwell` in DWELL_W: samples held per value; 0 treated as 1
- `cfg_blank` in DWELL_W: samples flagged at the start of each dwell
- `cfg_repeat` in 1: 1 = restart sweep from `cfg_start` on completion
- `cmd_go` in 1: start pulse
- `cmd_abort` in 1: abort pulse
- `sample_stb` in 1: one accepted sample (delay line `i_tvalid & o_tready`)
- `sel_data` out SIZE: delay select to the delay line
- `sel_valid` out 1: one-cycle load strobe for `sel_data`
- `blank` out 1: current sample lies inside the blanking window
- `busy` out 1: sweep in progress
- `done` out 1: one-cycle pulse on normal completion

## Operation
- States: IDLE, DWELL, STEP, DONE.
- IDLE: on `cmd_go`, latch all `cfg_*` into shadow registers, set `sel_data`=start, pulse `sel_valid`, clear the counter, and enter DWELL. Later `cfg_*` changes have no effect until the next go.
- DWELL: the counter increments on each `sample_stb`. When `sample_stb` arrives with count = dwell-1, enter STEP.
- STEP: next = `sel_data` + step, computed SIZE+1 bits wide.
  - If step = 0, or start > stop, or next > stop, the pass is complete. With repeat=1, reload start, pulse `sel_valid`, and return to DWELL. Otherwise enter DONE.
  - Otherwise set `sel_data`=next, pulse `sel_valid`, and return to DWELL.
- DONE: assert `done` for one cycle, then go to IDLE. `sel_data` holds its last value.
- `blank` is 1 in DWELL while count < blank. It is forced to 0 when `cfg_blank`=0.
- `cmd_abort`: from any state, go to IDLE the next cycle. No `sel_valid` or `done` pulse; `sel_data` holds. Abort wins over a simultaneous `cmd_go`.
- `cmd_go` while busy is ignored.
- Overflow: next wider than SIZE bits counts as > stop. The value never wraps.

## Timing
- Reset/clear values: `sel_data`=0, `sel_valid`=0, `blank`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- All outputs are registered.
- `cmd_go` sampled at edge k: after edge k, `busy`=1, `sel_valid`=1 (one cycle), and `sel_data`=start.
- A `sample_stb` in the same cycle as a `sel_valid` pulse is not counted. Counting starts the cycle after.
- The dwell-ending `sample_stb` at edge k gives STEP during cycle k+1. The new `sel_valid`/`sel_data` appear after edge k+1, so there is 1 idle cycle between values.
- `done`=1 for exactly one cycle. `busy` drops in the same cycle `done` rises.
- A `sample_stb` arriving during STEP or DONE is dropped, not counted.

## Configuration
- `DELAY_SWEEP_PINGPONG_EN`
  - Defined: when next > stop, direction reverses and values descend by step. The pass completes when the next descending value would be < start. Each endpoint is held for one dwell only, not two. Repeat restarts the ascent.
  - Undefined: ascending sweep only, as described in Operation.

## Test plan
- start=2, stop=8, step=3, dwell=4, repeat=0, continuous `sample_stb`:
  - `sel_valid` pulses with 2, 5, 8.
  - Each value held 4 strobes.
  - `done` pulses once, then `busy`=0 and `sel_data`=8.
- dwell=0, blank=0, start=stop=7:
  - A single `sel_valid` with 7.
  - One strobe later, `done` pulses.
  - `blank` never asserts.
- blank=2, dwell=5, strobes every 3rd cycle: `blank`=1 for exactly the first 2 strobes of each dwell.
- repeat=1, start=30, stop=31, step=1, SIZE=5:
  - Sequence 30, 31, 30, 31…
  - No wrap to 0, `done` never pulses.
  - Abort mid-dwell: `busy`=0 the next cycle, no `done`, `sel_data` held.
- `cmd_go` and `cmd_abort` in the same cycle gives state IDLE with no `sel_valid`. `cmd_go` while busy does not change the sequence.
- With `DELAY_SWEEP_PINGPONG_EN`, start=0, stop=6, step=2: sequence 0, 2, 4, 6, 4, 2, 0, then `done`.
